// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB pipeline slice: FSM states, default widths
// and the payload bundle that travels from MEM into writeback.
package mem_wb_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  typedef struct packed {
    logic                  write;
    logic                  mem_to_reg;
    logic [REG_AW_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] read_data;
    logic [DATA_W_DEF-1:0] alu_result;
  } mem_wb_payload_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus. The pipeline stage is the master and
// the memory is the slave.
interface mem_wb_stage_if
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/mem_wb_stage_reg.sv
// MEM/WB payload register: a clear (or reset) forces a bubble, otherwise the
// payload is captured only when load is asserted.
module mem_wb_reg
  import mem_wb_stage_pkg::*;
#(
  parameter type payload_t = mem_wb_payload_t
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clear,
  input  logic     load,
  input  payload_t d,
  output payload_t q
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: performs the data-memory access over a req/ack handshake, stalls
// the front of the pipeline while it is outstanding, and feeds the MEM/WB register.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_EM,
  input  logic              MemtoReg_EM,
  input  logic              MemRead_EM,
  input  logic              MemWrite_EM,
  input  logic [REG_AW-1:0] Addr_EM,
  input  logic [DATA_W-1:0] Rt_data_EM,
  input  logic [DATA_W-1:0] ALUResult_EM,
  mem_wb_stage_if.master    dmem,
  output logic              stall,
  output logic              write_MW,
  output logic              MemtoReg_MW,
  output logic [REG_AW-1:0] Addr_MW,
  output logic [DATA_W-1:0] ReadData_MW,
  output logic [DATA_W-1:0] ALUResult_MW
);

  typedef struct packed {
    logic              write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
  } payload_t;

  state_t            state;
  logic              op_write;
  logic              op_mem_to_reg;
  logic [REG_AW-1:0] op_addr;
  logic              mem_op;
  logic              load;
  logic              clear;
  payload_t          payload_d;
  payload_t          payload_q;

  assign mem_op = MemRead_EM | MemWrite_EM;

  always_comb begin
    stall     = 1'b0;
    load      = 1'b0;
    clear     = 1'b0;
    payload_d = '0;
    if (state == IDLE) begin
      stall                = mem_op;
      load                 = ~mem_op;
      clear                = mem_op;
      payload_d.write      = write_EM;
      payload_d.mem_to_reg = MemtoReg_EM;
      payload_d.addr       = Addr_EM;
      payload_d.alu_result = ALUResult_EM;
    end else begin
      // The latched ALU result doubles as the bus address held during WAIT
      stall                = ~dmem.ack;
      load                 = dmem.ack;
      payload_d.write      = op_write;
      payload_d.mem_to_reg = op_mem_to_reg;
      payload_d.addr       = op_addr;
      payload_d.read_data  = dmem.we ? '0 : dmem.rdata;
      payload_d.alu_result = dmem.addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      op_write      <= 1'b0;
      op_mem_to_reg <= 1'b0;
      op_addr       <= '0;
      dmem.req      <= 1'b0;
      dmem.we       <= 1'b0;
      dmem.addr     <= '0;
      dmem.wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            op_write      <= write_EM;
            op_mem_to_reg <= MemtoReg_EM;
            op_addr       <= Addr_EM;
            dmem.req      <= 1'b1;
            dmem.we       <= MemWrite_EM & ~MemRead_EM;
            dmem.addr     <= ALUResult_EM;
            dmem.wdata    <= Rt_data_EM;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (dmem.ack) begin
            dmem.req <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_wb_reg #(
    .payload_t(payload_t)
  ) u_mem_wb_reg (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .load (load),
    .d    (payload_d),
    .q    (payload_q)
  );

  assign write_MW     = payload_q.write;
  assign MemtoReg_MW  = payload_q.mem_to_reg;
  assign Addr_MW      = payload_q.addr;
  assign ReadData_MW  = payload_q.read_data;
  assign ALUResult_MW = payload_q.alu_result;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: the bench plays the data memory and
// scores MEM/WB results against expectations queued when each op is issued.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_em;
  logic        mem_to_reg_em;
  logic        mem_read_em;
  logic        mem_write_em;
  logic [4:0]  addr_em;
  logic [31:0] rt_data_em;
  logic [31:0] alu_result_em;
  logic        stall;
  logic        write_mw;
  logic        mem_to_reg_mw;
  logic [4:0]  addr_mw;
  logic [31:0] read_data_mw;
  logic [31:0] alu_result_mw;

  mem_wb_payload_t expected_q[$];
  int check_count = 0;
  int pass_count  = 0;

  always #5 clk = ~clk;

  mem_wb_stage_if #(.DATA_W(32)) dmem_bus ();

  mem_wb_stage dut (
    .clk         (clk),
    .rst         (rst),
    .write_EM    (write_em),
    .MemtoReg_EM (mem_to_reg_em),
    .MemRead_EM  (mem_read_em),
    .MemWrite_EM (mem_write_em),
    .Addr_EM     (addr_em),
    .Rt_data_EM  (rt_data_em),
    .ALUResult_EM(alu_result_em),
    .dmem        (dmem_bus),
    .stall       (stall),
    .write_MW    (write_mw),
    .MemtoReg_MW (mem_to_reg_mw),
    .Addr_MW     (addr_mw),
    .ReadData_MW (read_data_mw),
    .ALUResult_MW(alu_result_mw)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic w, input logic mtr, input logic rd, input logic wr,
                               input logic [4:0] addr, input logic [31:0] rt, input logic [31:0] alu);
    write_em      = w;
    mem_to_reg_em = mtr;
    mem_read_em   = rd;
    mem_write_em  = wr;
    addr_em       = addr;
    rt_data_em    = rt;
    alu_result_em = alu;
  endtask

  task automatic comparePayload(input string tag);
    mem_wb_payload_t e;
    checkOutput({tag, "_sb_level"}, 64'(expected_q.size()), 64'd1);
    if (expected_q.size() > 0) begin
      e = expected_q.pop_front();
      checkOutput({tag, "_write_mw"}, 64'(write_mw), 64'(e.write));
      checkOutput({tag, "_memtoreg_mw"}, 64'(mem_to_reg_mw), 64'(e.mem_to_reg));
      checkOutput({tag, "_addr_mw"}, 64'(addr_mw), 64'(e.addr));
      checkOutput({tag, "_readdata_mw"}, 64'(read_data_mw), 64'(e.read_data));
      checkOutput({tag, "_aluresult_mw"}, 64'(alu_result_mw), 64'(e.alu_result));
    end
  endtask

  // Plain ALU op: result must appear one edge later with no stall and no request
  task automatic aluOp(input string tag, input logic w, input logic mtr, input logic [4:0] addr,
                       input logic [31:0] alu, input logic spurious_ack);
    mem_wb_payload_t e;
    applyStimulus(w, mtr, 1'b0, 1'b0, addr, 32'h5555_5555, alu);
    dmem_bus.ack   = spurious_ack;
    dmem_bus.rdata = 32'hBAD0_BAD0;
    e = '{write: w, mem_to_reg: mtr, addr: addr, read_data: 32'h0, alu_result: alu};
    expected_q.push_back(e);
    #1 checkOutput({tag, "_stall"}, 64'(stall), 64'd0);
    @(negedge clk);
    dmem_bus.ack = 1'b0;
    checkOutput({tag, "_req"}, 64'(dmem_bus.req), 64'd0);
    comparePayload(tag);
  endtask

  // Memory op: wait_cycles is the number of WAIT cycles before the ack cycle
  task automatic memOp(input string tag, input logic rd, input logic wr, input logic w, input logic mtr,
                       input logic [4:0] addr, input logic [31:0] alu, input logic [31:0] rt,
                       input int wait_cycles, input logic [31:0] rdata);
    mem_wb_payload_t e;
    logic exp_we;
    exp_we = wr & ~rd;
    applyStimulus(w, mtr, rd, wr, addr, rt, alu);
    e = '{write: w, mem_to_reg: mtr, addr: addr, read_data: (rd ? rdata : 32'h0), alu_result: alu};
    expected_q.push_back(e);
    #1 checkOutput({tag, "_stall_issue"}, 64'(stall), 64'd1);
    @(negedge clk);
    // EX/MEM garbage while waiting must be ignored
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 5'h1F, 32'hFFFF_FFFF, 32'hCAFE_F00D);
    checkOutput({tag, "_req"}, 64'(dmem_bus.req), 64'd1);
    checkOutput({tag, "_we"}, 64'(dmem_bus.we), 64'(exp_we));
    checkOutput({tag, "_addr"}, 64'(dmem_bus.addr), 64'(alu));
    checkOutput({tag, "_wdata"}, 64'(dmem_bus.wdata), 64'(rt));
    checkOutput({tag, "_bubble"}, 64'(write_mw), 64'd0);
    for (int i = 0; i < wait_cycles; i++) begin
      #1 checkOutput({tag, "_stall_wait"}, 64'(stall), 64'd1);
      @(negedge clk);
      checkOutput({tag, "_req_hold"}, 64'(dmem_bus.req), 64'd1);
      checkOutput({tag, "_we_hold"}, 64'(dmem_bus.we), 64'(exp_we));
      checkOutput({tag, "_addr_hold"}, 64'(dmem_bus.addr), 64'(alu));
      checkOutput({tag, "_write_wait"}, 64'(write_mw), 64'd0);
    end
    dmem_bus.ack   = 1'b1;
    dmem_bus.rdata = rdata;
    #1 checkOutput({tag, "_stall_ack"}, 64'(stall), 64'd0);
    @(negedge clk);
    dmem_bus.ack   = 1'b0;
    dmem_bus.rdata = 32'h0BAD_0BAD;
    checkOutput({tag, "_req_drop"}, 64'(dmem_bus.req), 64'd0);
    comparePayload(tag);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0, 32'h0);
  endtask

  initial begin
    rst            = 1'b1;
    dmem_bus.ack   = 1'b0;
    dmem_bus.rdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("rst_req", 64'(dmem_bus.req), 64'd0);
    checkOutput("rst_we", 64'(dmem_bus.we), 64'd0);
    checkOutput("rst_addr", 64'(dmem_bus.addr), 64'd0);
    checkOutput("rst_wdata", 64'(dmem_bus.wdata), 64'd0);
    checkOutput("rst_write_mw", 64'(write_mw), 64'd0);
    checkOutput("rst_memtoreg_mw", 64'(mem_to_reg_mw), 64'd0);
    checkOutput("rst_alu_mw", 64'(alu_result_mw), 64'd0);
    checkOutput("rst_stall", 64'(stall), 64'd0);
    rst = 1'b0;

    aluOp("alu", 1'b1, 1'b0, 5'd3, 32'h10, 1'b0);
    memOp("load", 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h100, 32'h0, 2, 32'hDEAD_BEEF);
    memOp("store", 1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 32'h40, 32'h1234, 0, 32'h7777_7777);
    memOp("dual", 1'b1, 1'b1, 1'b1, 1'b1, 5'd6, 32'h8, 32'hAAAA, 1, 32'h1234_5678);

    // Reset in WAIT abandons the load; a late ack must not revive it
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h0, 32'h200);
    @(negedge clk);
    checkOutput("rstwait_req_up", 64'(dmem_bus.req), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstwait_req", 64'(dmem_bus.req), 64'd0);
    checkOutput("rstwait_write_mw", 64'(write_mw), 64'd0);
    @(negedge clk);
    dmem_bus.ack   = 1'b1;
    dmem_bus.rdata = 32'h1111_1111;
    #1 checkOutput("rstwait_stall", 64'(stall), 64'd0);
    @(negedge clk);
    dmem_bus.ack = 1'b0;
    checkOutput("lateack_req", 64'(dmem_bus.req), 64'd0);
    checkOutput("lateack_write_mw", 64'(write_mw), 64'd0);
    checkOutput("lateack_readdata_mw", 64'(read_data_mw), 64'd0);
    checkOutput("lateack_addr_mw", 64'(addr_mw), 64'd0);
    checkOutput("lateack_alu_mw", 64'(alu_result_mw), 64'd0);

    aluOp("spurious_ack", 1'b1, 1'b0, 5'd3, 32'h10, 1'b1);
    aluOp("alu_mtr", 1'b0, 1'b1, 5'd17, 32'h8000_0001, 1'b0);

    checkOutput("sb_drained", 64'(expected_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
